// File: rtl/bus_arbiter_pkg.sv
// Shared encodings and types for the bus_arbiter codebase slice.
// The optional watchdog is enabled by defining ARB_TIMEOUT_EN.
package bus_arbiter_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic WriteEnable = 1'b1;

    localparam int unsigned RegBusWidth      = 32;
    localparam int unsigned InstAddrBusWidth = 32;

    typedef logic [RegBusWidth-1:0]      reg_bus_t;
    typedef logic [InstAddrBusWidth-1:0] inst_addr_t;

    localparam logic [1:0] ArbIdle      = 2'd0;
    localparam logic [1:0] ArbIfBusy    = 2'd1;
    localparam logic [1:0] ArbMemBusy   = 2'd2;
    localparam logic [1:0] ArbFlushWait = 2'd3;

    localparam int unsigned DefaultTimeoutCycles = 255;

    // Registered attributes of the transaction currently on the bus.
    typedef struct packed {
        logic     we;
        logic [3:0] sel;
        reg_bus_t addr;
        reg_bus_t wdata;
    } bus_attr_t;

    localparam bus_attr_t BusAttrReset = '{we: 1'b0, sel: 4'h0, addr: '0, wdata: '0};

    function automatic logic arb_busy(input logic [1:0] st);
        return st != ArbIdle;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle counter for bus_arbiter; flags an access that has waited too long for ack.
// Only instantiated when ARB_TIMEOUT_EN is defined.
module arb_watchdog
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic busy_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam int unsigned NeedW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CntW  = (NeedW > 8) ? NeedW : 8;

    logic [CntW-1:0] cnt_q;
    logic            leaving;

    // Counter holds the number of busy cycles already completed in this access.
    assign expire_o = busy_i && !ack_i && (cnt_q == CntW'(TIMEOUT_CYCLES));
    assign leaving  = ack_i || expire_o;

    always_ff @(posedge clk_i) begin
        if (rst_i == RstEnable) begin
            cnt_q <= '0;
        end else if (!busy_i || leaving) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the single memory port between fetch and the MEM stage, one access at a time.
// Define ARB_TIMEOUT_EN to abort accesses that see no bus_ack within TIMEOUT_CYCLES.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,

    input  logic       if_req,
    input  inst_addr_t if_addr,
    output reg_bus_t   if_data,
    output logic       stallreq_if,

    input  logic       mem_req,
    input  logic       mem_we,
    input  logic [3:0] mem_sel,
    input  reg_bus_t   mem_addr,
    input  reg_bus_t   mem_wdata,
    output reg_bus_t   mem_rdata,
    output logic       stallreq_mem,

    output logic       bus_cyc,
    output logic       bus_stb,
    output logic       bus_we,
    output logic [3:0] bus_sel,
    output reg_bus_t   bus_addr,
    output reg_bus_t   bus_wdata,
    input  reg_bus_t   bus_rdata,
    input  logic       bus_ack,
    output logic       bus_timeout
);

    logic [1:0] state_q, state_d;
    logic       cyc_q, cyc_d;
    bus_attr_t  attr_q, attr_d;
    logic       busy;
    logic       expire;
    logic       xfer_done;

    assign busy      = arb_busy(state_q);
    assign xfer_done = bus_ack || expire;

`ifdef ARB_TIMEOUT_EN
    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_arb_watchdog (
        .clk_i   (clk),
        .rst_i   (rst),
        .busy_i  (busy),
        .ack_i   (bus_ack),
        .expire_o(expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign expire         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        attr_d  = attr_q;
        case (state_q)
            ArbIdle: begin
                // A flush in IDLE suppresses issue for one cycle so the redirect settles.
                if (!flush) begin
                    if (mem_req == ChipEnable) begin
                        state_d      = ArbMemBusy;
                        cyc_d        = 1'b1;
                        attr_d.we    = mem_we;
                        attr_d.sel   = mem_sel;
                        attr_d.addr  = mem_addr;
                        attr_d.wdata = mem_wdata;
                    end else if (if_req == ChipEnable) begin
                        state_d      = ArbIfBusy;
                        cyc_d        = 1'b1;
                        attr_d.we    = 1'b0;
                        attr_d.sel   = 4'hF;
                        attr_d.addr  = if_addr;
                        attr_d.wdata = '0;
                    end
                end
            end
            ArbIfBusy: begin
                if (xfer_done) begin
                    state_d = ArbIdle;
                    cyc_d   = 1'b0;
                end else if (flush) begin
                    state_d = ArbFlushWait;
                end
            end
            ArbMemBusy, ArbFlushWait: begin
                if (xfer_done) begin
                    state_d = ArbIdle;
                    cyc_d   = 1'b0;
                end
            end
            default: begin
                state_d = ArbIdle;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= ArbIdle;
            cyc_q   <= 1'b0;
            attr_q  <= BusAttrReset;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            attr_q  <= attr_d;
        end
    end

    always_comb begin
        if_data   = '0;
        mem_rdata = '0;
        if (state_q == ArbIfBusy && bus_ack && !flush) begin
            if_data = bus_rdata;
        end
        // Stores hand back zero rather than whatever the slave drives.
        if (state_q == ArbMemBusy && bus_ack && attr_q.we != WriteEnable) begin
            mem_rdata = bus_rdata;
        end
    end

    assign stallreq_if  = (if_req == ChipEnable) &&
                          !(state_q == ArbIfBusy && xfer_done && !flush);
    assign stallreq_mem = (mem_req == ChipEnable) && !(state_q == ArbMemBusy && xfer_done);

    assign bus_cyc     = cyc_q;
    assign bus_stb     = cyc_q;
    assign bus_we      = attr_q.we;
    assign bus_sel     = attr_q.sel;
    assign bus_addr    = attr_q.addr;
    assign bus_wdata   = attr_q.wdata;
    assign bus_timeout = expire;

endmodule
